soc_ctrl_domain_pwr_seq: RTL and testbench

- Driver side of a clock domain's reset and clock-enable pair. It produces the `arst_no` / `clk_en_o` that feed the domain's clock/reset delay generator.
- Power-up sequence: release reset, wait long enough to cover the downstream delay window, then raise clock enable.
- Power-down sequence: drop clock enable, drain, assert reset, hold reset, then report off.
- One instance per gated domain in soc_ctrl. Sequenced by software/PMU through a pulse request / done interface.

---
 rtl/soc_ctrl_pkg.sv | 19 +
 rtl/soc_ctrl_seq_timer.sv | 26 ++
 rtl/soc_ctrl_domain_pwr_seq.sv | 116 +++++++++++
 tb/tb_soc_ctrl_domain_pwr_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ctrl_pkg.sv
// Shared types and helpers for the soc_ctrl power/clock sequencers.
package soc_ctrl_pkg;

  typedef enum logic [2:0] {
    StOff,
    StRelease,
    StOn,
    StDrain,
    StHold
  } pwr_seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soc_ctrl_seq_timer.sv
// Loadable down-counter; expired_o is high while the count reads zero.
module soc_ctrl_seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ref_clk_i,
  input  logic             intr_arst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge ref_clk_i or negedge intr_arst_n) begin
    if (!intr_arst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/soc_ctrl_domain_pwr_seq.sv
// Reset / clock-enable sequencer for one gated clock domain.
module soc_ctrl_domain_pwr_seq
  import soc_ctrl_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 64,
  parameter int unsigned DRAIN_CYCLES   = 8,
  parameter int unsigned HOLD_CYCLES    = 4
) (
  input  logic ref_clk_i,
  input  logic intr_arst_n,
  input  logic on_req_i,
  input  logic off_req_i,
  output logic arst_no,
  output logic clk_en_o,
  output logic on_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned TimerW =
      $clog2(max3(RELEASE_CYCLES, DRAIN_CYCLES, HOLD_CYCLES) + 1);

  pwr_seq_state_e    state_q, state_d;
  logic              load;
  logic [TimerW-1:0] load_val;
  logic              expired;
  logic              enter_done;
  logic              done_pend_q;
  logic              arst_q, clk_en_q, on_q, busy_q, done_q;

  soc_ctrl_seq_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .ref_clk_i   (ref_clk_i),
    .intr_arst_n (intr_arst_n),
    .load_i      (load),
    .load_val_i  (load_val),
    .expired_o   (expired)
  );

  // The timer is loaded on the edge that enters a timed state.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_val   = '0;
    enter_done = 1'b0;
    case (state_q)
      StOff: begin
        if (on_req_i) begin
          state_d  = StRelease;
          load     = 1'b1;
          load_val = TimerW'(RELEASE_CYCLES - 1);
        end
      end
      StRelease: begin
        if (off_req_i) begin
          state_d  = StHold;
          load     = 1'b1;
          load_val = TimerW'(HOLD_CYCLES - 1);
        end else if (expired) begin
          state_d    = StOn;
          enter_done = 1'b1;
        end
      end
      StOn: begin
        if (off_req_i) begin
          state_d  = StDrain;
          load     = 1'b1;
          load_val = TimerW'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (expired) begin
          state_d  = StHold;
          load     = 1'b1;
          load_val = TimerW'(HOLD_CYCLES - 1);
        end
      end
      StHold: begin
        if (expired) begin
          state_d    = StOff;
          enter_done = 1'b1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge ref_clk_i or negedge intr_arst_n) begin
    if (!intr_arst_n) begin
      state_q     <= StOff;
      done_pend_q <= 1'b0;
      arst_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      on_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= enter_done;
      arst_q      <= (state_q == StRelease) || (state_q == StOn) || (state_q == StDrain);
      clk_en_q    <= (state_q == StOn);
      on_q        <= (state_q == StOn);
      busy_q      <= (state_q == StRelease) || (state_q == StDrain) || (state_q == StHold);
      done_q      <= done_pend_q;
    end
  end

  assign arst_no  = arst_q;
  assign clk_en_o = clk_en_q;
  assign on_o     = on_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_soc_ctrl_domain_pwr_seq.sv
// Bench for soc_ctrl_domain_pwr_seq against a timestamp-based phase model.
module tb_soc_ctrl_domain_pwr_seq;

  localparam int unsigned R = 4;
  localparam int unsigned D = 2;
  localparam int unsigned H = 3;

  logic ref_clk_i = 1'b0;
  logic intr_arst_n = 1'b0;
  logic on_req_i = 1'b0;
  logic off_req_i = 1'b0;
  logic arst_no, clk_en_o, on_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  // Model: phase 0 off, 1 release, 2 on, 3 drain, 4 hold; m_end is the leaving edge.
  int   m_phase = 0;
  int   m_end = 0;
  int   cyc = 0;
  bit   m_entered = 1'b0;
  logic e_arst = 1'b0, e_clk = 1'b0, e_on = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  soc_ctrl_domain_pwr_seq #(
    .RELEASE_CYCLES (R),
    .DRAIN_CYCLES   (D),
    .HOLD_CYCLES    (H)
  ) dut (
    .ref_clk_i   (ref_clk_i),
    .intr_arst_n (intr_arst_n),
    .on_req_i    (on_req_i),
    .off_req_i   (off_req_i),
    .arst_no     (arst_no),
    .clk_en_o    (clk_en_o),
    .on_o        (on_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge ref_clk_i) begin
    if (inv_en) begin
      checks++;
      if (clk_en_o && !arst_no) begin
        errors++;
        $display("FAIL invariant: clk_en_o=%b with arst_no=%b required arst_no=1", clk_en_o,
                 arst_no);
      end
    end
  end

  task automatic model_reset();
    m_phase = 0; m_entered = 1'b0;
    e_arst = 0; e_clk = 0; e_on = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic model_edge(input bit on, input bit off);
    cyc++;
    // Outputs after this edge reflect the phase held before it.
    e_arst = (m_phase >= 1 && m_phase <= 3);
    e_clk  = (m_phase == 2);
    e_on   = (m_phase == 2);
    e_busy = (m_phase == 1 || m_phase == 3 || m_phase == 4);
    e_done = m_entered;
    m_entered = 1'b0;
    case (m_phase)
      0: if (on) begin m_phase = 1; m_end = cyc + R; end
      1: begin
        if (off) begin m_phase = 4; m_end = cyc + H; end
        else if (cyc == m_end) begin m_phase = 2; m_entered = 1'b1; end
      end
      2: if (off) begin m_phase = 3; m_end = cyc + D; end
      3: if (cyc == m_end) begin m_phase = 4; m_end = cyc + H; end
      4: if (cyc == m_end) begin m_phase = 0; m_entered = 1'b1; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input bit on, input bit off);
    on_req_i = on; off_req_i = off;
    @(posedge ref_clk_i);
    model_edge(on, off);
    #1;
    on_req_i = 1'b0; off_req_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (arst_no !== 1'b0) begin errors++; $display("FAIL reset_arst: got %b want 0", arst_no); end
    if (clk_en_o !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b want 0", clk_en_o); end
    if (on_o !== 1'b0) begin errors++; $display("FAIL reset_on: got %b want 0", on_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    @(negedge ref_clk_i);
    intr_arst_n = 1'b1;
    inv_en = 1'b1;
    repeat (3) step(0, 0);
  endtask

  task automatic test_power_up();
    int done_at = -1;
    int arst_at = -1;
    step(1, 0);
    for (int i = 1; i <= int'(R) + 3; i++) begin
      step(0, 0);
      checks += 4;
      if (arst_no !== e_arst) begin errors++; $display("FAIL up_arst[%0d]: got %b want %b", i, arst_no, e_arst); end
      if (clk_en_o !== e_clk) begin errors++; $display("FAIL up_clk_en[%0d]: got %b want %b", i, clk_en_o, e_clk); end
      if (busy_o !== e_busy) begin errors++; $display("FAIL up_busy[%0d]: got %b want %b", i, busy_o, e_busy); end
      if (done_o !== e_done) begin errors++; $display("FAIL up_done[%0d]: got %b want %b", i, done_o, e_done); end
      if (arst_no && arst_at < 0) arst_at = i;
      if (done_o && done_at < 0) done_at = i;
    end
    checks += 3;
    if (arst_at != 1) begin errors++; $display("FAIL up_arst_latency: got %0d want 1", arst_at); end
    if (done_at != int'(R) + 1) begin errors++; $display("FAIL up_done_latency: got %0d want %0d", done_at, R + 1); end
    if (on_o !== 1'b1) begin errors++; $display("FAIL up_on: got %b want 1", on_o); end
  endtask

  task automatic test_power_down();
    int clk_off_at = -1;
    int arst_off_at = -1;
    int done_at = -1;
    step(0, 1);
    for (int i = 1; i <= int'(D + H) + 3; i++) begin
      step(0, 0);
      checks += 4;
      if (arst_no !== e_arst) begin errors++; $display("FAIL down_arst[%0d]: got %b want %b", i, arst_no, e_arst); end
      if (clk_en_o !== e_clk) begin errors++; $display("FAIL down_clk_en[%0d]: got %b want %b", i, clk_en_o, e_clk); end
      if (on_o !== e_on) begin errors++; $display("FAIL down_on[%0d]: got %b want %b", i, on_o, e_on); end
      if (done_o !== e_done) begin errors++; $display("FAIL down_done[%0d]: got %b want %b", i, done_o, e_done); end
      if (!clk_en_o && clk_off_at < 0) clk_off_at = i;
      if (!arst_no && arst_off_at < 0) arst_off_at = i;
      if (done_o && done_at < 0) done_at = i;
    end
    checks += 3;
    if (clk_off_at != 1) begin errors++; $display("FAIL down_clk_latency: got %0d want 1", clk_off_at); end
    if (arst_off_at != int'(D) + 1) begin errors++; $display("FAIL down_arst_latency: got %0d want %0d", arst_off_at, D + 1); end
    if (done_at != int'(D + H) + 1) begin errors++; $display("FAIL down_done_latency: got %0d want %0d", done_at, D + H + 1); end
  endtask

  task automatic test_abort();
    int  done_at = -1;
    bit  clk_seen = 1'b0;
    step(1, 0);
    step(0, 0);
    if (clk_en_o) clk_seen = 1'b1;
    step(0, 1);
    if (clk_en_o) clk_seen = 1'b1;
    for (int i = 1; i <= int'(H) + 3; i++) begin
      step(0, 0);
      checks += 3;
      if (arst_no !== e_arst) begin errors++; $display("FAIL abort_arst[%0d]: got %b want %b", i, arst_no, e_arst); end
      if (busy_o !== e_busy) begin errors++; $display("FAIL abort_busy[%0d]: got %b want %b", i, busy_o, e_busy); end
      if (done_o !== e_done) begin errors++; $display("FAIL abort_done[%0d]: got %b want %b", i, done_o, e_done); end
      if (clk_en_o) clk_seen = 1'b1;
      if (done_o && done_at < 0) done_at = i;
    end
    checks += 2;
    if (clk_seen) begin errors++; $display("FAIL abort_clk_en: got 1 during abort want 0"); end
    if (done_at != int'(H) + 1) begin errors++; $display("FAIL abort_done_latency: got %0d want %0d", done_at, H + 1); end
  endtask

  task automatic test_ignored();
    // off in OFF, both in OFF, run up, both in ON, on during DRAIN, off during HOLD.
    bit on_seq[20]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    bit off_seq[20] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      step(on_seq[i], off_seq[i]);
      checks += 5;
      if (arst_no !== e_arst) begin errors++; $display("FAIL ign_arst[%0d]: got %b want %b", i, arst_no, e_arst); end
      if (clk_en_o !== e_clk) begin errors++; $display("FAIL ign_clk_en[%0d]: got %b want %b", i, clk_en_o, e_clk); end
      if (on_o !== e_on) begin errors++; $display("FAIL ign_on[%0d]: got %b want %b", i, on_o, e_on); end
      if (busy_o !== e_busy) begin errors++; $display("FAIL ign_busy[%0d]: got %b want %b", i, busy_o, e_busy); end
      if (done_o !== e_done) begin errors++; $display("FAIL ign_done[%0d]: got %b want %b", i, done_o, e_done); end
    end
  endtask

  task automatic test_reset_mid_release();
    int done_at = -1;
    bit done_seen = 1'b0;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    #2;
    intr_arst_n = 1'b0;
    inv_en = 1'b0;
    #1;
    checks += 3;
    if (arst_no !== 1'b0) begin errors++; $display("FAIL mid_rst_arst: got %b want 0", arst_no); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
    if (clk_en_o !== 1'b0 || on_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_other: clk_en=%b on=%b done=%b want 0", clk_en_o, on_o, done_o);
    end
    model_reset();
    repeat (2) step(0, 0);
    @(negedge ref_clk_i);
    intr_arst_n = 1'b1;
    inv_en = 1'b1;
    repeat (R + 2) begin
      step(0, 0);
      if (done_o) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL mid_rst_no_done: got done pulse want none"); end
    step(1, 0);
    for (int i = 1; i <= int'(R) + 2; i++) begin
      step(0, 0);
      if (done_o && done_at < 0) done_at = i;
    end
    checks++;
    if (done_at != int'(R) + 1) begin errors++; $display("FAIL mid_rst_full_release: got %0d want %0d", done_at, R + 1); end
  endtask

  task automatic test_random();
    bit on, off;
    for (int i = 0; i < 400; i++) begin
      on  = ($urandom_range(0, 5) == 0);
      off = ($urandom_range(0, 6) == 0);
      step(on, off);
      checks += 5;
      if (arst_no !== e_arst) begin errors++; $display("FAIL rnd_arst[%0d]: got %b want %b", i, arst_no, e_arst); end
      if (clk_en_o !== e_clk) begin errors++; $display("FAIL rnd_clk_en[%0d]: got %b want %b", i, clk_en_o, e_clk); end
      if (on_o !== e_on) begin errors++; $display("FAIL rnd_on[%0d]: got %b want %b", i, on_o, e_on); end
      if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy_o, e_busy); end
      if (done_o !== e_done) begin errors++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done_o, e_done); end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    repeat (3) step(0, 0);
    test_power_down();
    repeat (2) step(0, 0);
    test_abort();
    repeat (2) step(0, 0);
    test_ignored();
    repeat (2) step(0, 0);
    test_reset_mid_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
